motor_ramp_ctrl: RTL

Soft-start PWM motor drive controller. It accepts a target duty and direction from the control logic and ramps the applied 10-bit duty toward that target by a fixed step once per PWM period. On a direction reversal it decelerates to zero, holds a dead time and then re-accelerates. It owns the PWM counter and comparator through one sub-module, and sits between the control loop and the H-bridge pins.

---
 rtl/motor_ramp_ctrl_pkg.sv | 39 +++
 rtl/motor_ramp_ctrl_pwm10.sv | 36 +++
 rtl/motor_ramp_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/motor_ramp_ctrl_pkg.sv
// Shared definitions for the soft-start motor drive: state encoding, PWM
// period constants and the saturating ramp step.
package motor_ramp_ctrl_pkg;

  localparam int PERIOD_W = 10;
  localparam logic [PERIOD_W-1:0] PERIOD_MAX = 10'd1023;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DECEL = 3'd3,
    ST_DEAD  = 3'd4,
    ST_ESTOP = 3'd5
  } state_e;

  // Move cur toward tgt by at most step; the gap is taken in 11 bits so neither direction can overshoot.
  function automatic logic [PERIOD_W-1:0] ramp_step(input logic [PERIOD_W-1:0] cur,
                                                    input logic [PERIOD_W-1:0] tgt,
                                                    input logic [PERIOD_W-1:0] step);
    logic [PERIOD_W:0]   gap;
    logic [PERIOD_W-1:0] res;
    gap = 11'd0;
    res = cur;
    if (cur < tgt) begin
      gap = {1'b0, tgt} - {1'b0, cur};
      if (gap <= {1'b0, step}) res = tgt;
      else                     res = cur + step;
    end else if (cur > tgt) begin
      gap = {1'b0, cur} - {1'b0, tgt};
      if (gap <= {1'b0, step}) res = tgt;
      else                     res = cur - step;
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/motor_ramp_ctrl_pwm10.sv
// Free-running 10-bit PWM counter with a registered comparator. The comparator
// sees the next counter value and next duty so PWM_sig lines up with duty.
module motor_ramp_ctrl_pwm10
  import motor_ramp_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [PERIOD_W-1:0] duty_i,
  output logic                pwm_o,
  output logic                boundary_o
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                pwm_q, pwm_d;

  // Next counter value and comparator result.
  always_comb begin
    cnt_d = cnt_q + 10'd1;
    pwm_d = (cnt_d < duty_i);
  end

  // Counter and PWM output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 10'd0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o      = pwm_q;
  assign boundary_o = (cnt_q == PERIOD_MAX);

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Soft-start H-bridge controller: ramps the applied duty toward a latched
// target once per PWM period, with decel/dead-time sequencing on reversal.
module motor_ramp_ctrl
  import motor_ramp_ctrl_pkg::*;
#(
  parameter int unsigned STEP         = 8,
  parameter int unsigned DEAD_PERIODS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic [PERIOD_W-1:0] target_duty,
  input  logic                dir_req,
  input  logic                estop,
  output logic [PERIOD_W-1:0] duty,
  output logic                PWM_sig,
  output logic                fwd,
  output logic                rev,
  output logic                busy,
  output logic                at_target
);

  localparam logic [PERIOD_W-1:0] STEP_V    = PERIOD_W'(STEP);
  localparam logic [3:0]          DEAD_LAST = 4'(DEAD_PERIODS - 1);

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] duty_q, duty_d, tgt_q, tgt_d;
  logic [PERIOD_W-1:0] step_duty, decel_duty;
  logic                cur_dir_q, cur_dir_d, pend_dir_q, pend_dir_d;
  logic [3:0]          dead_cnt_q, dead_cnt_d;
  logic                fwd_q, rev_q, busy_q, at_target_q;
  logic                dir_on, boundary;

  motor_ramp_ctrl_pwm10 u_pwm (
    .clk        (clk),
    .rst        (rst),
    .duty_i     (duty_d),
    .pwm_o      (PWM_sig),
    .boundary_o (boundary)
  );

  // Next-state, ramp arithmetic and dead-time counting; estop overrides everything but rst.
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    tgt_d      = tgt_q;
    cur_dir_d  = cur_dir_q;
    pend_dir_d = pend_dir_q;
    dead_cnt_d = dead_cnt_q;
    step_duty  = ramp_step(duty_q, tgt_q, STEP_V);
    decel_duty = ramp_step(duty_q, 10'd0, STEP_V);
    if (estop) begin
      state_d = ST_ESTOP;
      duty_d  = 10'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          duty_d = 10'd0;
          if (go && (target_duty != 10'd0)) begin
            tgt_d      = target_duty;
            cur_dir_d  = dir_req;
            pend_dir_d = dir_req;
            state_d    = ST_RAMP;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RAMP, ST_HOLD: begin
          // A go suppresses this cycle's step so the new target takes effect from the next boundary.
          if (go) begin
            tgt_d      = target_duty;
            pend_dir_d = dir_req;
            state_d    = (dir_req == cur_dir_q) ? ST_RAMP : ST_DECEL;
          end else if ((state_q == ST_RAMP) && boundary) begin
            duty_d = step_duty;
            if (step_duty == tgt_q) state_d = (tgt_q == 10'd0) ? ST_IDLE : ST_HOLD;
            else                    state_d = ST_RAMP;
          end else begin
            state_d = state_q;
          end
        end
        ST_DECEL: begin
          if (go) begin
            tgt_d      = target_duty;
            pend_dir_d = dir_req;
            state_d    = (dir_req == cur_dir_q) ? ST_RAMP : ST_DECEL;
          end else if (boundary) begin
            duty_d = decel_duty;
            if (decel_duty == 10'd0) begin
              state_d    = ST_DEAD;
              dead_cnt_d = 4'd0;
            end else begin
              state_d = ST_DECEL;
            end
          end else begin
            state_d = ST_DECEL;
          end
        end
        ST_DEAD: begin
          if (go) begin
            tgt_d      = target_duty;
            pend_dir_d = dir_req;
          end else begin
            tgt_d = tgt_q;
          end
          if (boundary) begin
            if (dead_cnt_q == DEAD_LAST) begin
              dead_cnt_d = 4'd0;
              cur_dir_d  = pend_dir_d;
              state_d    = (tgt_d == 10'd0) ? ST_IDLE : ST_RAMP;
            end else begin
              dead_cnt_d = dead_cnt_q + 4'd1;
            end
          end else begin
            dead_cnt_d = dead_cnt_q;
          end
        end
        ST_ESTOP: begin
          state_d = ST_IDLE;
          tgt_d   = 10'd0;
          duty_d  = 10'd0;
        end
        default: begin
          state_d = ST_IDLE;
          duty_d  = 10'd0;
        end
      endcase
    end
  end

  assign dir_on = (state_d == ST_RAMP) || (state_d == ST_HOLD) || (state_d == ST_DECEL);

  // State, datapath and registered output flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      duty_q      <= 10'd0;
      tgt_q       <= 10'd0;
      cur_dir_q   <= 1'b0;
      pend_dir_q  <= 1'b0;
      dead_cnt_q  <= 4'd0;
      fwd_q       <= 1'b0;
      rev_q       <= 1'b0;
      busy_q      <= 1'b0;
      at_target_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      tgt_q       <= tgt_d;
      cur_dir_q   <= cur_dir_d;
      pend_dir_q  <= pend_dir_d;
      dead_cnt_q  <= dead_cnt_d;
      fwd_q       <= dir_on & cur_dir_d;
      rev_q       <= dir_on & ~cur_dir_d;
      busy_q      <= (state_d == ST_RAMP) || (state_d == ST_DECEL) || (state_d == ST_DEAD);
      at_target_q <= (state_d == ST_HOLD);
    end
  end

  assign duty      = duty_q;
  assign fwd       = fwd_q;
  assign rev       = rev_q;
  assign busy      = busy_q;
  assign at_target = at_target_q;

endmodule
